// File: rtl/stream_mux3_pkg.sv
// Shared types and helpers for the stream_mux3 3-to-1 stream arbiter.
// The source codes match the select encoding of the companion 1-to-3 demux.
package stream_mux3_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_CH1  = 2'b00;
    localparam sel_t SEL_CH2  = 2'b01;
    localparam sel_t SEL_CH3  = 2'b10;
    localparam sel_t SEL_IDLE = 2'b11;

    // Channel that follows ptr in round-robin order (ch1 -> ch2 -> ch3 -> ch1).
    function automatic sel_t next_rr(sel_t ptr);
        case (ptr)
            SEL_CH1: return SEL_CH2;
            SEL_CH2: return SEL_CH3;
            default: return SEL_CH1;
        endcase
    endfunction

    // True when the channel named by s is requesting.
    function automatic logic req_hit(logic [2:0] req, sel_t s);
        case (s)
            SEL_CH1: return req[0];
            SEL_CH2: return req[1];
            SEL_CH3: return req[2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stream_mux3_rr_arb3.sv
// rr_arb3: three-way grant generator for stream_mux3.
// Default build: round-robin, pointer starts at ch3 so ch1 wins first and
// moves to the winner only on an accepted transfer (advance).
// With STREAM_MUX3_FIXED_PRIO_EN defined: fixed priority ch1 > ch2 > ch3,
// no pointer is kept.
import stream_mux3_pkg::*;

module rr_arb3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       advance,
    output logic [2:0] gnt,
    output sel_t       gnt_sel
);

`ifdef STREAM_MUX3_FIXED_PRIO_EN

    logic unused_ports;
    assign unused_ports = ^{clk, rst, advance};

    // Lowest-numbered requesting channel wins.
    always_comb begin
        gnt_sel = SEL_IDLE;
        if (req[0])
            gnt_sel = SEL_CH1;
        else if (req[1])
            gnt_sel = SEL_CH2;
        else if (req[2])
            gnt_sel = SEL_CH3;
    end

`else

    sel_t ptr;
    sel_t cand;

    // Pointer remembers the last winner; idle and stalled cycles leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= SEL_CH3;
        else if (advance)
            ptr <= gnt_sel;
    end

    // Scan the three channels starting just after the pointer; first requester wins.
    always_comb begin
        gnt_sel = SEL_IDLE;
        cand    = next_rr(ptr);
        for (int i = 0; i < 3; i++) begin
            if (gnt_sel == SEL_IDLE && req_hit(req, cand))
                gnt_sel = cand;
            cand = next_rr(cand);
        end
    end

`endif

    // One-hot view of the winning channel.
    always_comb begin
        gnt = 3'b000;
        case (gnt_sel)
            SEL_CH1: gnt = 3'b001;
            SEL_CH2: gnt = 3'b010;
            SEL_CH3: gnt = 3'b100;
            default: gnt = 3'b000;
        endcase
    end

endmodule

// File: rtl/stream_mux3.sv
// stream_mux3: merges three valid/ready channels onto one registered output,
// tagging each word with its source code on y_sel (00/01/10, 11 = none).
// Arbitration policy is chosen by STREAM_MUX3_FIXED_PRIO_EN inside rr_arb3
// (undefined: round-robin; defined: fixed ch1 > ch2 > ch3).
//
// Handshake: a word moves when valid && ready are both high at a rising edge.
// Producers hold valid and data until accepted. The output register reloads
// only when it is empty or being drained (load), so at most one xN_ready is
// high and none is high while the output is stalled.
import stream_mux3_pkg::*;

module stream_mux3 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x1_data,
    input  logic             x1_valid,
    output logic             x1_ready,
    input  logic [WIDTH-1:0] x2_data,
    input  logic             x2_valid,
    output logic             x2_ready,
    input  logic [WIDTH-1:0] x3_data,
    input  logic             x3_valid,
    output logic             x3_ready,
    output logic [WIDTH-1:0] y_data,
    output logic [1:0]       y_sel,
    output logic             y_valid,
    input  logic             y_ready
);

    logic             load;
    logic             advance;
    logic [2:0]       req;
    logic [2:0]       gnt;
    sel_t             gnt_sel;
    logic [WIDTH-1:0] gnt_data;

    assign load    = !y_valid || y_ready;
    assign req     = {x3_valid, x2_valid, x1_valid};
    assign advance = load && (gnt_sel != SEL_IDLE);

    rr_arb3 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .gnt     (gnt),
        .gnt_sel (gnt_sel)
    );

    assign x1_ready = load && gnt[0];
    assign x2_ready = load && gnt[1];
    assign x3_ready = load && gnt[2];

    // Data of the winning channel.
    always_comb begin
        gnt_data = '0;
        case (gnt_sel)
            SEL_CH1: gnt_data = x1_data;
            SEL_CH2: gnt_data = x2_data;
            SEL_CH3: gnt_data = x3_data;
            default: gnt_data = '0;
        endcase
    end

    // Output register: refill on load, empty when nothing is granted; data/sel keep last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_sel   <= SEL_IDLE;
        end else if (load) begin
            if (advance) begin
                y_valid <= 1'b1;
                y_data  <= gnt_data;
                y_sel   <= gnt_sel;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux3.sv
// Self-checking bench for stream_mux3: directed vectors with literal expectations
// plus a per-cycle reference model and per-channel order scoreboard.
module tb_stream_mux3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] x1_data = '0, x2_data = '0, x3_data = '0;
    logic        x1_valid = 1'b0, x2_valid = 1'b0, x3_valid = 1'b0;
    logic        x1_ready, x2_ready, x3_ready;
    logic [15:0] y_data;
    logic [1:0]  y_sel;
    logic        y_valid;
    logic        y_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic        m_valid;
    logic [15:0] m_data;
    logic [1:0]  m_sel;
    int          m_ptr;
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] q3[$];

    stream_mux3 #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .x1_data  (x1_data),
        .x1_valid (x1_valid),
        .x1_ready (x1_ready),
        .x2_data  (x2_data),
        .x2_valid (x2_valid),
        .x2_ready (x2_ready),
        .x3_data  (x3_data),
        .x3_valid (x3_valid),
        .x3_ready (x3_ready),
        .y_data   (y_data),
        .y_sel    (y_sel),
        .y_valid  (y_valid),
        .y_ready  (y_ready)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] t3_data(input int ch);
        case (ch)
            0: return 16'h1111;
            1: return 16'h2222;
            default: return 16'h3333;
        endcase
    endfunction

    // Scoreboard pop: the word leaving on y must be the oldest accepted word of its source.
    task automatic sb_pop(input logic [1:0] sel, input logic [15:0] data);
        logic [15:0] e;
        check("y_sel_not_idle", {31'd0, sel == 2'b11}, 32'd0);
        case (sel)
            2'b00: begin
                check("sb_ch1_nonempty", {31'd0, q1.size() != 0}, 32'd1);
                if (q1.size() != 0) begin e = q1.pop_front(); check("sb_ch1_order", data, e); end
            end
            2'b01: begin
                check("sb_ch2_nonempty", {31'd0, q2.size() != 0}, 32'd1);
                if (q2.size() != 0) begin e = q2.pop_front(); check("sb_ch2_order", data, e); end
            end
            2'b10: begin
                check("sb_ch3_nonempty", {31'd0, q3.size() != 0}, 32'd1);
                if (q3.size() != 0) begin e = q3.pop_front(); check("sb_ch3_order", data, e); end
            end
            default: ;
        endcase
    endtask

    // Reference model + compare: runs on every falling edge.
    task automatic compare_loop();
        logic [2:0] v, r, er;
        logic       ld;
        int         g, c;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_valid = 1'b0;
                m_data  = '0;
                m_sel   = 2'b11;
                m_ptr   = 2;
                q1.delete();
                q2.delete();
                q3.delete();
            end else begin
                check("m_y_valid", y_valid, m_valid);
                check("m_y_data", y_data, m_data);
                check("m_y_sel", y_sel, m_sel);
                if (y_valid && y_ready)
                    sb_pop(y_sel, y_data);

                v  = {x3_valid, x2_valid, x1_valid};
                r  = {x3_ready, x2_ready, x1_ready};
                ld = !m_valid || y_ready;
                g  = -1;
                if (ld) begin
                    for (int k = 0; k < 3; k++) begin
                        c = (m_ptr + 1 + k) % 3;
                        if (g < 0 && v[c]) g = c;
                    end
                end
                er = 3'b000;
                if (g >= 0) er[g] = 1'b1;
                check("m_x_ready", r, er);

                if (x1_valid && x1_ready) q1.push_back(x1_data);
                if (x2_valid && x2_ready) q2.push_back(x2_data);
                if (x3_valid && x3_ready) q3.push_back(x3_data);

                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_sel   = 2'(g);
                    m_data  = (g == 0) ? x1_data : (g == 1) ? x2_data : x3_data;
`ifndef STREAM_MUX3_FIXED_PRIO_EN
                    m_ptr   = g;
`endif
                end else if (ld) begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic a1, a2, a3;
        int   exp_sel;

        fork
            compare_loop();
        join_none

        // reset state
        repeat (3) step();
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_y_sel", y_sel, 2'b11);
        rst = 1'b0;
        step();

        // single channel on ch2
        x2_data = 16'h1234; x2_valid = 1'b1; y_ready = 1'b1;
        #1;
        check("single_x2_ready", x2_ready, 1);
        check("single_x1_ready", x1_ready, 0);
        check("single_x3_ready", x3_ready, 0);
        step();
        x2_valid = 1'b0;
        check("single_y_data", y_data, 16'h1234);
        check("single_y_sel", y_sel, 2'b01);
        check("single_y_valid", y_valid, 1);

        // idle drain
        step();
        check("drain_y_valid", y_valid, 0);
        check("drain_y_data_hold", y_data, 16'h1234);
        check("drain_y_sel_hold", y_sel, 2'b01);

        // backpressure
        x1_data = 16'hA0A0; x1_valid = 1'b1; y_ready = 1'b0;
        step();
        x1_valid = 1'b0;
        x2_data = 16'h5555; x2_valid = 1'b1;
        x3_data = 16'h6666; x3_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_y_data", y_data, 16'hA0A0);
            check("bp_y_sel", y_sel, 2'b00);
            check("bp_y_valid", y_valid, 1);
            check("bp_readies", {x3_ready, x2_ready, x1_ready}, 3'b000);
            step();
        end
        y_ready = 1'b1;
        #1;
        check("bp_release_x2_ready", x2_ready, 1);
        step();
        x2_valid = 1'b0;
        check("bp_y_data_ch2", y_data, 16'h5555);
        check("bp_y_sel_ch2", y_sel, 2'b01);
        #1;
        check("bp_x3_ready", x3_ready, 1);
        step();
        x3_valid = 1'b0;
        check("bp_y_data_ch3", y_data, 16'h6666);
        check("bp_y_sel_ch3", y_sel, 2'b10);
        step();
        check("bp_empty", y_valid, 0);

        // reset mid-stream
        x1_data = 16'hBEEF; x1_valid = 1'b1; y_ready = 1'b0;
        step();
        x1_valid = 1'b0;
        check("pre_rst_y_data", y_data, 16'hBEEF);
        check("pre_rst_y_valid", y_valid, 1);
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_y_valid", y_valid, 0);
        check("mid_rst_y_data", y_data, 0);
        check("mid_rst_y_sel", y_sel, 2'b11);
        x1_data = 16'h1111; x2_data = 16'h2222; x3_data = 16'h3333;
        x1_valid = 1'b1; x2_valid = 1'b1; x3_valid = 1'b1; y_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("post_rst_x1_first", {x3_ready, x2_ready, x1_ready}, 3'b001);

        // all three valid continuously
        for (int i = 0; i < 6; i++) begin
            step();
`ifdef STREAM_MUX3_FIXED_PRIO_EN
            exp_sel = 0;
`else
            exp_sel = i % 3;
`endif
            check("rr_y_sel", y_sel, exp_sel);
            check("rr_y_data", y_data, t3_data(exp_sel));
        end
        x1_valid = 1'b0; x2_valid = 1'b0; x3_valid = 1'b0;
        repeat (2) step();

        // random valids and backpressure
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            a1 = x1_valid && x1_ready;
            a2 = x2_valid && x2_ready;
            a3 = x3_valid && x3_ready;
            @(posedge clk);
            #1;
            if (!x1_valid || a1) begin x1_valid = 1'($urandom_range(0, 1)); x1_data = 16'($urandom); end
            if (!x2_valid || a2) begin x2_valid = 1'($urandom_range(0, 1)); x2_data = 16'($urandom); end
            if (!x3_valid || a3) begin x3_valid = 1'($urandom_range(0, 1)); x3_data = 16'($urandom); end
            y_ready = ($urandom_range(0, 9) < 7);
        end
        x1_valid = 1'b0; x2_valid = 1'b0; x3_valid = 1'b0; y_ready = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
